// File: rtl/dll_tx_sched.sv
// dll_tx_sched -- Data Link Layer TX scheduler.
//
// Shares the single PHY TX slot between TLPs from the Transaction Layer and
// DLLPs (Ack/Nak, InitFC/UpdateFC). Traffic is gated by the DLCMSM state.
// Each TLP is stamped with NEXT_TRANSMIT_SEQ. One registered beat is held
// toward the PHY framer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   dlc_state_i           DLCMSM state (11 active, 10 init, else inactive)
//   tlp_*                 TLP request/payload/blocked, tlp_ready_o = accepted
//   acknak_*              Ack/Nak DLLP request, acknak_ready_o = accepted
//   fc_*                  FC DLLP request/body, fc_ready_o = accepted
//   tx_valid_o/tx_ready_i output beat handshake toward the PHY
//   tx_is_dllp_o          1 = DLLP beat, 0 = TLP beat
//   tx_data_o             TLP: {tlp, 8'h00}; DLLP: {dllp32, zero pad}
//   tx_seq_o              sequence number of a TLP beat, 0 on DLLP beats
//   next_seq_o            current NEXT_TRANSMIT_SEQ
module dll_tx_sched #(
  parameter int unsigned TLP_W          = 128,
  parameter int unsigned SEQ_W          = 12,
  parameter int unsigned TLP_STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         dlc_state_i,
  input  logic               tlp_valid_i,
  input  logic [TLP_W-1:0]   tlp_i,
  input  logic               tlp_block_i,
  output logic               tlp_ready_o,
  input  logic               acknak_valid_i,
  input  logic               acknak_nak_i,
  input  logic [SEQ_W-1:0]   acknak_seq_i,
  output logic               acknak_ready_o,
  input  logic               fc_valid_i,
  input  logic [31:0]        fc_dllp_i,
  output logic               fc_ready_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic               tx_is_dllp_o,
  output logic [TLP_W+7:0]   tx_data_o,
  output logic [SEQ_W-1:0]   tx_seq_o,
  output logic [SEQ_W-1:0]   next_seq_o
);

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'b00,
    DL_INIT     = 2'b10,
    DL_ACTIVE   = 2'b11
  } dl_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ACKNAK,
    GNT_FC,
    GNT_TLP
  } gnt_e;

  localparam logic [3:0] STARVE_MAX = 4'(TLP_STARVE_MAX);

  dl_state_e          dl_st;
  gnt_e               gnt;
  logic               slot_free;
  logic               tlp_elig;
  logic               acknak_elig;
  logic               fc_elig;
  logic [31:0]        acknak_body;

  logic               tx_valid_d,   tx_valid_q;
  logic               tx_is_dllp_d, tx_is_dllp_q;
  logic [TLP_W+7:0]   tx_data_d,    tx_data_q;
  logic [SEQ_W-1:0]   tx_seq_d,     tx_seq_q;
  logic [SEQ_W-1:0]   next_seq_d,   next_seq_q;
  logic [3:0]         starve_cnt_d, starve_cnt_q;

  // Encoding 2'b01 is treated as inactive.
  always_comb begin
    case (dlc_state_i)
      2'b11:   dl_st = DL_ACTIVE;
      2'b10:   dl_st = DL_INIT;
      default: dl_st = DL_INACTIVE;
    endcase
  end

  always_comb begin
    acknak_body                = '0;
    acknak_body[SEQ_W-1:0]     = acknak_seq_i;
    acknak_body[31:24]         = acknak_nak_i ? 8'h10 : 8'h00;
  end

  // Arbitration. A single Ack/Nak port carries both kinds, so Nak-over-Ack
  // ordering is resolved by the generator that drives it.
  always_comb begin
    gnt         = GNT_NONE;
    slot_free   = !tx_valid_q || tx_ready_i;
    tlp_elig    = (dl_st == DL_ACTIVE) && tlp_valid_i && !tlp_block_i;
    acknak_elig = (dl_st == DL_ACTIVE) && acknak_valid_i;
    fc_elig     = (dl_st != DL_INACTIVE) && fc_valid_i;
    // Readies are held low while in reset.
    if (rst_n && slot_free) begin
      if (tlp_elig && (starve_cnt_q == STARVE_MAX)) begin
        gnt = GNT_TLP;
      end else if (acknak_elig) begin
        gnt = GNT_ACKNAK;
      end else if (fc_elig) begin
        gnt = GNT_FC;
      end else if (tlp_elig) begin
        gnt = GNT_TLP;
      end
    end
  end

  assign tlp_ready_o    = (gnt == GNT_TLP);
  assign acknak_ready_o = (gnt == GNT_ACKNAK);
  assign fc_ready_o     = (gnt == GNT_FC);

  always_comb begin
    tx_valid_d   = tx_valid_q;
    tx_is_dllp_d = tx_is_dllp_q;
    tx_data_d    = tx_data_q;
    tx_seq_d     = tx_seq_q;
    next_seq_d   = next_seq_q;
    starve_cnt_d = starve_cnt_q;
    if (dl_st == DL_INACTIVE) begin
      // Link down: drop any held beat and restart sequence numbering.
      tx_valid_d   = 1'b0;
      tx_is_dllp_d = 1'b0;
      tx_data_d    = '0;
      tx_seq_d     = '0;
      next_seq_d   = '0;
      starve_cnt_d = '0;
    end else begin
      if (!tlp_elig || (gnt == GNT_TLP)) begin
        starve_cnt_d = '0;
      end else if ((gnt == GNT_ACKNAK || gnt == GNT_FC) &&
                   (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
      if (slot_free) begin
        tx_valid_d = 1'b0;
      end
      case (gnt)
        GNT_ACKNAK: begin
          tx_valid_d                   = 1'b1;
          tx_is_dllp_d                 = 1'b1;
          tx_data_d                    = '0;
          tx_data_d[TLP_W+7 -: 32]     = acknak_body;
          tx_seq_d                     = '0;
        end
        GNT_FC: begin
          tx_valid_d                   = 1'b1;
          tx_is_dllp_d                 = 1'b1;
          tx_data_d                    = '0;
          tx_data_d[TLP_W+7 -: 32]     = fc_dllp_i;
          tx_seq_d                     = '0;
        end
        GNT_TLP: begin
          tx_valid_d                   = 1'b1;
          tx_is_dllp_d                 = 1'b0;
          tx_data_d                    = {tlp_i, 8'h00};
          tx_seq_d                     = next_seq_q;
          next_seq_d                   = next_seq_q + SEQ_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid_q   <= 1'b0;
      tx_is_dllp_q <= 1'b0;
      tx_data_q    <= '0;
      tx_seq_q     <= '0;
      next_seq_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      tx_valid_q   <= tx_valid_d;
      tx_is_dllp_q <= tx_is_dllp_d;
      tx_data_q    <= tx_data_d;
      tx_seq_q     <= tx_seq_d;
      next_seq_q   <= next_seq_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign tx_valid_o   = tx_valid_q;
  assign tx_is_dllp_o = tx_is_dllp_q;
  assign tx_data_o    = tx_data_q;
  assign tx_seq_o     = tx_seq_q;
  assign next_seq_o   = next_seq_q;

endmodule

// File: tb/tb_dll_tx_sched.sv
module tb_dll_tx_sched;

  localparam int TLP_W = 128;
  localparam int SEQ_W = 12;
  localparam int MAXS  = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       dlc_state;
  logic             tlp_valid, tlp_block, tlp_ready;
  logic [TLP_W-1:0] tlp;
  logic             acknak_valid, acknak_nak, acknak_ready;
  logic [SEQ_W-1:0] acknak_seq;
  logic             fc_valid, fc_ready;
  logic [31:0]      fc_dllp;
  logic             tx_valid, tx_ready, tx_is_dllp;
  logic [135:0]     tx_data;
  logic [SEQ_W-1:0] tx_seq, next_seq;

  always #5 clk = ~clk;

  dll_tx_sched #(
    .TLP_W(TLP_W),
    .SEQ_W(SEQ_W),
    .TLP_STARVE_MAX(MAXS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dlc_state_i(dlc_state),
    .tlp_valid_i(tlp_valid),
    .tlp_i(tlp),
    .tlp_block_i(tlp_block),
    .tlp_ready_o(tlp_ready),
    .acknak_valid_i(acknak_valid),
    .acknak_nak_i(acknak_nak),
    .acknak_seq_i(acknak_seq),
    .acknak_ready_o(acknak_ready),
    .fc_valid_i(fc_valid),
    .fc_dllp_i(fc_dllp),
    .fc_ready_o(fc_ready),
    .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready),
    .tx_is_dllp_o(tx_is_dllp),
    .tx_data_o(tx_data),
    .tx_seq_o(tx_seq),
    .next_seq_o(next_seq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the beat the PHY should be seeing, plus scheduler state.
  bit           m_valid;
  bit           m_dllp;
  logic [135:0] m_data;
  int           m_seq;
  int           m_next;
  int           m_starve;
  int           tlp_grants;

  task automatic model_reset();
    m_valid  = 0;
    m_dllp   = 0;
    m_data   = '0;
    m_seq    = 0;
    m_next   = 0;
    m_starve = 0;
  endtask

  // 0 none, 1 Ack/Nak, 2 FC, 3 TLP
  function automatic int expected_winner();
    bit act, ini, tlp_ok;
    act    = (dlc_state == 2'b11);
    ini    = (dlc_state == 2'b10);
    tlp_ok = act && tlp_valid && !tlp_block;
    if (!(act || ini))         return 0;
    if (m_valid && !tx_ready)  return 0;
    if (tlp_ok && m_starve == MAXS) return 3;
    if (act && acknak_valid)   return 1;
    if (fc_valid)              return 2;
    if (tlp_ok)                return 3;
    return 0;
  endfunction

  // Inputs are applied just after a negedge; check, then advance one clock.
  task automatic cycle();
    int w;
    bit act, ini, tlp_ok;
    #1;
    w = expected_winner();
    check("tx_valid", 136'(tx_valid), 136'(m_valid));
    if (m_valid) begin
      check("tx_is_dllp", 136'(tx_is_dllp), 136'(m_dllp));
      check("tx_data", tx_data, m_data);
      check("tx_seq", 136'(tx_seq), 136'(m_seq));
    end
    check("next_seq", 136'(next_seq), 136'(m_next));
    check("acknak_ready", 136'(acknak_ready), 136'(w == 1));
    check("fc_ready", 136'(fc_ready), 136'(w == 2));
    check("tlp_ready", 136'(tlp_ready), 136'(w == 3));
    if (tlp_ready === 1'b1) tlp_grants++;
    @(posedge clk);
    act    = (dlc_state == 2'b11);
    ini    = (dlc_state == 2'b10);
    tlp_ok = act && tlp_valid && !tlp_block;
    if (!(act || ini)) begin
      m_valid  = 0;
      m_next   = 0;
      m_starve = 0;
    end else begin
      if (!tlp_ok || w == 3) m_starve = 0;
      else if (w == 1 || w == 2) m_starve = (m_starve < MAXS) ? m_starve + 1 : MAXS;
      if (!m_valid || tx_ready) m_valid = 0;
      if (w == 1) begin
        m_valid = 1; m_dllp = 1; m_seq = 0;
        m_data  = {(acknak_nak ? 8'h10 : 8'h00), 12'h000, acknak_seq, 104'd0};
      end else if (w == 2) begin
        m_valid = 1; m_dllp = 1; m_seq = 0;
        m_data  = {fc_dllp, 104'd0};
      end else if (w == 3) begin
        m_valid = 1; m_dllp = 0;
        m_data  = {tlp, 8'h00};
        m_seq   = m_next;
        m_next  = (m_next + 1) % 4096;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    tlp        = {$urandom, $urandom, $urandom, $urandom};
    fc_dllp    = $urandom;
    acknak_seq = 12'($urandom_range(0, 4095));
  endtask

  task automatic set_valids(input bit t, input bit a, input bit n, input bit f);
    tlp_valid    = t;
    acknak_valid = a;
    acknak_nak   = n;
    fc_valid     = f;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"}, 136'(tx_valid), 136'(0));
    check({tag, "_tx_is_dllp"}, 136'(tx_is_dllp), 136'(0));
    check({tag, "_tx_data"}, tx_data, 136'(0));
    check({tag, "_tx_seq"}, 136'(tx_seq), 136'(0));
    check({tag, "_next_seq"}, 136'(next_seq), 136'(0));
    check({tag, "_readies"}, 136'({tlp_ready, acknak_ready, fc_ready}), 136'(0));
  endtask

  initial begin
    tlp_grants = 0;
    rst_n      = 1'b0;
    dlc_state  = 2'b00;
    tlp_block  = 1'b0;
    tx_ready   = 1'b1;
    set_valids(1, 1, 0, 1);
    rand_payload();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Inactive link: nothing may be granted with every request raised.
    repeat (20) cycle();

    // Init: FC only.
    dlc_state = 2'b10;
    for (int i = 0; i < 30; i++) begin
      rand_payload();
      tx_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Active: 4097 back-to-back TLPs wrap the sequence number.
    dlc_state = 2'b11;
    set_valids(1, 0, 0, 0);
    tx_ready  = 1'b1;
    for (int i = 0; i < 4097; i++) begin
      rand_payload();
      cycle();
    end
    set_valids(0, 0, 0, 0);
    #1;
    check("wrap_tx_seq", 136'(tx_seq), 136'(0));
    check("wrap_next_seq", 136'(next_seq), 136'(1));
    cycle();
    cycle();

    // Priority: Nak, then Ack, then FC, then TLP.
    rand_payload();
    set_valids(1, 1, 1, 1);
    #1;
    check("prio_nak", 136'({acknak_ready, fc_ready, tlp_ready}), 136'(3'b100));
    cycle();
    set_valids(1, 1, 0, 1);
    cycle();
    set_valids(1, 0, 0, 1);
    #1;
    check("prio_fc", 136'({acknak_ready, fc_ready, tlp_ready}), 136'(3'b010));
    cycle();
    set_valids(1, 0, 0, 0);
    #1;
    check("prio_tlp", 136'({acknak_ready, fc_ready, tlp_ready}), 136'(3'b001));
    cycle();
    set_valids(0, 0, 0, 0);
    cycle();

    // Starvation guard: 4 FC beats then one TLP, repeating.
    set_valids(1, 0, 0, 1);
    tlp_grants = 0;
    for (int i = 0; i < 10; i++) begin
      rand_payload();
      cycle();
    end
    check("starve_tlp_grants", 136'(tlp_grants), 136'(2));
    tlp_block  = 1'b1;
    tlp_grants = 0;
    for (int i = 0; i < 10; i++) begin
      rand_payload();
      cycle();
    end
    check("blocked_tlp_grants", 136'(tlp_grants), 136'(0));
    tlp_block = 1'b0;

    // Backpressure on a TLP beat, then link drop mid-hold.
    set_valids(0, 0, 0, 0);
    cycle();
    cycle();
    rand_payload();
    set_valids(1, 0, 0, 0);
    tx_ready = 1'b0;
    cycle();
    set_valids(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      rand_payload();
      cycle();
    end
    dlc_state = 2'b00;
    cycle();
    #1;
    check("drop_tx_valid", 136'(tx_valid), 136'(0));
    check("drop_next_seq", 136'(next_seq), 136'(0));
    @(negedge clk);

    // Randomized traffic with occasional state changes.
    dlc_state = 2'b11;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        case ($urandom_range(0, 5))
          0:       dlc_state = 2'b00;
          1:       dlc_state = 2'b01;
          2:       dlc_state = 2'b10;
          default: dlc_state = 2'b11;
        endcase
      end
      rand_payload();
      set_valids($urandom_range(0, 1), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 1), ($urandom_range(0, 1) == 0));
      tlp_block = ($urandom_range(0, 4) == 0);
      tx_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Async reset while a beat is held.
    dlc_state = 2'b11;
    tlp_block = 1'b0;
    tx_ready  = 1'b1;
    set_valids(0, 0, 0, 0);
    cycle();
    rand_payload();
    set_valids(1, 0, 0, 0);
    tx_ready = 1'b0;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_valids(0, 0, 0, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
